// File: rtl/uart_tx_peripheral.sv
//------------------------------------------------------------------------------
// uart_tx_peripheral
//
// Memory-mapped UART transmitter. It has a byte FIFO in front of an 8N1 serial
// framer. The processor pushes bytes by writing the TX data word. It can read
// a status word and clear the sticky overflow flag through the status word.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent after the 8
//                      data bits, which makes the frame 11 bits long. Status
//                      bit 7 then reads 1.
//
// Parameters:
//   BASE_ADDR     word address of the TX data register (write-only);
//                 the status register is at BASE_ADDR+1
//   CLKS_PER_BIT  clock cycles per serial bit, 2..65535
//   FIFO_DEPTH    TX FIFO entries, power of two, 2..64
//
// Ports:
//   clock    system clock, all logic on the rising edge
//   reset    asynchronous, active-high reset
//   data     shared 64-bit processor data bus. The status word is driven only
//            while the status register is being read.
//   address  processor word address
//   read     processor read strobe
//   write    processor write strobe
//   txd      serial output, idle high, driven straight from a flop
//   irq      high while the FIFO is empty and the transmitter is idle
//
// Status word layout (low byte, upper 56 bits zero):
//   [7] parity build, [6:4] 0, [3] busy, [2] overflow, [1] empty, [0] full
//
// Transmit FSM:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | line high, waiting for the FIFO to hold a byte
//   ST_START  | start bit (txd=0) for CLKS_PER_BIT cycles
//   ST_DATA   | 8 data bits, LSB first, CLKS_PER_BIT cycles each
//   ST_PARITY | even parity bit (parity build only)
//   ST_STOP   | stop bit (txd=1). At its end the next byte is popped, or
//             | the FSM returns to idle.
//------------------------------------------------------------------------------
module uart_tx_peripheral #(
    parameter logic [63:0] BASE_ADDR    = 64'h0000_0000_0000_F000,
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    inout  wire  [63:0] data,
    input  logic [63:0] address,
    input  logic        read,
    input  logic        write,
    output logic        txd,
    output logic        irq
);

    localparam logic [63:0] STAT_ADDR = BASE_ADDR + 64'd1;
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_FLAG = 1'b1;
`else
    localparam logic PARITY_FLAG = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // -------------------------------------------------------------------------
    // Register decode
    // -------------------------------------------------------------------------
    logic push_req;
    logic clr_req;
    logic stat_rd;

    assign push_req = write && (address == BASE_ADDR);
    assign clr_req  = write && (address == STAT_ADDR) && data[2];
    assign stat_rd  = read  && (address == STAT_ADDR);

    // Only the low byte of a data write is stored. The rest of the bus is
    // ignored.
    logic unused_data_hi;
    assign unused_data_hi = ^data[63:8];

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             push_drop;
    logic [7:0]       head_byte;

    state_t           state;
    logic [15:0]      bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == COUNT_FULL);
    assign head_byte  = fifo_mem[rd_ptr];

    // A byte is popped when an idle FSM sees data, or on the last cycle of a
    // stop bit, so that the next start bit follows with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && (bit_cnt == '0)));

    // When the FIFO is full, a push that coincides with a pop still fits.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign push_drop = push_req && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // If a drop and a clear happen in the same cycle, the drop wins.
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (clr_req) begin
                overflow <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM. bit_cnt is a down-counter that is reloaded with
    // CLKS_PER_BIT-1 on every bit boundary. Reaching zero ends the bit.
    // -------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    logic parity_bit;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            txd       <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        state     <= ST_START;
                        txd       <= 1'b0;
                        shift_reg <= head_byte;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head_byte;
`endif
                        bit_cnt   <= BIT_LAST;
                        bit_idx   <= '0;
                    end
                end

                ST_START: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        state   <= ST_DATA;
                        txd     <= shift_reg[0];
                        bit_cnt <= BIT_LAST;
                        bit_idx <= '0;
                    end
                end

                ST_DATA: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        bit_cnt <= BIT_LAST;
`ifdef UART_TX_PARITY_EN
                        state   <= ST_PARITY;
                        txd     <= parity_bit;
`else
                        state   <= ST_STOP;
                        txd     <= 1'b1;
`endif
                    end else begin
                        // shift_reg[0] is the bit on the line now, so
                        // shift_reg[1] is the next one.
                        bit_idx   <= bit_idx + 1'b1;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        txd       <= shift_reg[1];
                        bit_cnt   <= BIT_LAST;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else begin
                        state   <= ST_STOP;
                        txd     <= 1'b1;
                        bit_cnt <= BIT_LAST;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end else if (pop) begin
                        state     <= ST_START;
                        txd       <= 1'b0;
                        shift_reg <= head_byte;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head_byte;
`endif
                        bit_cnt   <= BIT_LAST;
                        bit_idx   <= '0;
                    end else begin
                        state <= ST_IDLE;
                        txd   <= 1'b1;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    txd     <= 1'b1;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    logic       busy;
    logic [7:0] status_byte;

    assign busy        = (state != ST_IDLE);
    assign irq         = !busy && fifo_empty;
    assign status_byte = {PARITY_FLAG, 3'b000, busy, overflow, fifo_empty, fifo_full};

    // The data register is write-only, so a read of it leaves the bus
    // released.
    assign data = stat_rd ? {56'b0, status_byte} : 64'bz;

endmodule

// File: tb/tb_uart_tx_peripheral.sv
`timescale 1ns/1ps
module tb_uart_tx_peripheral;

    localparam logic [63:0] BASE  = 64'h0000_0000_0000_F000;
    localparam logic [63:0] STAT  = BASE + 64'd1;
    localparam int          C     = 4;
    localparam int          D     = 4;
`ifdef UART_TX_PARITY_EN
    localparam int          NB    = 11;
    localparam logic        PAR   = 1'b1;
`else
    localparam int          NB    = 10;
    localparam logic        PAR   = 1'b0;
`endif
    localparam int          FL    = NB * C;
    // Pattern the bench drives onto the bus to show the DUT is not driving it.
    localparam logic [63:0] PROBE = 64'h5A5A_5A5A_5A5A_5A00;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [63:0] address  = '0;
    logic        read     = 1'b0;
    logic        write    = 1'b0;
    logic        tb_drv   = 1'b0;
    logic [63:0] tb_wdata = '0;
    wire  [63:0] data;
    logic        txd;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign data = tb_drv ? tb_wdata : 64'bz;

    always #5 clock = ~clock;

    uart_tx_peripheral #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (D)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .data   (data),
        .address(address),
        .read   (read),
        .write  (write),
        .txd    (txd),
        .irq    (irq)
    );

    // ------------------------------------------------------------------
    // Reference model: a byte queue, plus the position inside the current
    // frame. The line level is worked out from the frame slot number.
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    logic       m_active;
    int         m_pos;
    logic [7:0] m_cur;
    logic       m_ovf;

    function automatic void m_clear();
        mq.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_cur    = '0;
        m_ovf    = 1'b0;
    endfunction

    function automatic logic exp_txd();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_pos / C;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_cur[slot-1];
        if (PAR && slot == 9) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic logic exp_irq();
        return !m_active && (mq.size() == 0);
    endfunction

    function automatic logic [63:0] exp_status();
        return {56'b0, PAR, 3'b000, m_active, m_ovf, (mq.size() == 0), (mq.size() == D)};
    endfunction

    // One clock edge: the DUT advances and the model applies the same
    // inputs. The task returns 1 ns after the edge.
    task automatic step();
        logic       pop;
        logic       acc;
        logic [7:0] popped;
        @(posedge clock);
        cyc++;
        if (!reset) begin
            pop    = (mq.size() != 0) && (!m_active || m_pos == FL - 1);
            acc    = 1'b0;
            popped = '0;
            if (write && address == STAT && tb_wdata[2]) m_ovf = 1'b0;
            if (write && address == BASE) begin
                if (mq.size() < D || pop) acc = 1'b1;
                else m_ovf = 1'b1;
            end
            if (pop) popped = mq.pop_front();
            if (acc) mq.push_back(tb_wdata[7:0]);
            if (pop) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_cur    = popped;
            end else if (m_active) begin
                if (m_pos == FL - 1) m_active = 1'b0;
                else m_pos++;
            end
        end
        #1;
    endtask

    task automatic bus_write(input logic [63:0] addr, input logic [63:0] val);
        address  = addr;
        tb_wdata = val;
        tb_drv   = 1'b1;
        write    = 1'b1;
        step();
        write    = 1'b0;
        tb_drv   = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] val);
        address = addr;
        read    = 1'b1;
        #1;
        val     = data;
        read    = 1'b0;
    endtask

    // The bench drives PROBE while reading. If the DUT stays off the bus,
    // the bench reads PROBE back unchanged.
    task automatic bus_probe(input logic [63:0] addr, output logic [63:0] val);
        address  = addr;
        tb_wdata = PROBE;
        tb_drv   = 1'b1;
        read     = 1'b1;
        #1;
        val      = data;
        read     = 1'b0;
        tb_drv   = 1'b0;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [63:0] v;
        reset = 1'b1;
        m_clear();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL reset_txd got %b want 1", txd);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL reset_irq got %b want 1", irq);
        end
        bus_read(STAT, v);
        checks++;
        if (v !== {56'b0, PAR, 7'h02}) begin
            errors++; $display("FAIL reset_status got %h want %h", v, {56'b0, PAR, 7'h02});
        end
        bus_probe(BASE, v);
        checks++;
        if (v !== PROBE) begin
            errors++; $display("FAIL read_data_reg_released got %h want %h", v, PROBE);
        end
        bus_probe(BASE + 64'd2, v);
        checks++;
        if (v !== PROBE) begin
            errors++; $display("FAIL read_unmatched_released got %h want %h", v, PROBE);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [63:0] w;
        int          lows;
        w       = rand64();
        w[7:0]  = 8'hA5;
        lows    = 0;
        bus_write(BASE, w);
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL frame_push_edge_txd got %b want 1", txd);
        end
        for (int i = 0; i < FL + 4; i++) begin
            step();
            if (txd === 1'b0) lows++;
            checks++;
            if (txd !== exp_txd()) begin
                errors++; $display("FAIL frame_txd cyc=%0d got %b want %b", cyc, txd, exp_txd());
            end
            checks++;
            if (irq !== exp_irq()) begin
                errors++; $display("FAIL frame_irq cyc=%0d got %b want %b", cyc, irq, exp_irq());
            end
        end
        // For A5, 1 start slot plus 4 zero data slots are low. Its parity
        // bit is 0, so the parity build has one more low slot.
        checks++;
        if (lows != (PAR ? 6 * C : 5 * C)) begin
            errors++; $display("FAIL frame_low_cycles got %0d want %0d", lows, (PAR ? 6 * C : 5 * C));
        end
    endtask

    task automatic test_overflow();
        logic [63:0] v;
        for (int i = 0; i < 6; i++) bus_write(BASE, rand64());
        bus_read(STAT, v);
        checks++;
        if (v !== exp_status()) begin
            errors++; $display("FAIL ovf_status_model got %h want %h", v, exp_status());
        end
        checks++;
        if (v !== {56'b0, PAR, 7'h0D}) begin
            errors++; $display("FAIL ovf_status_busy_ovf_full got %h want %h", v, {56'b0, PAR, 7'h0D});
        end
        bus_write(STAT, 64'h4);
        bus_read(STAT, v);
        checks++;
        if (v[2] !== 1'b0 || v !== exp_status()) begin
            errors++; $display("FAIL ovf_clear got %h want %h", v, exp_status());
        end
        for (int i = 0; i < 5 * FL + 4; i++) begin
            step();
            checks++;
            if (txd !== exp_txd()) begin
                errors++; $display("FAIL ovf_drain_txd cyc=%0d got %b want %b", cyc, txd, exp_txd());
            end
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL ovf_drain_idle_irq got %b want 1", irq);
        end
    endtask

    task automatic test_back_to_back();
        int k_irq;
        k_irq = -1;
        for (int i = 0; i < 3; i++) bus_write(BASE, rand64());
        for (int k = 0; k < 3 * FL + 6; k++) begin
            step();
            if (k_irq < 0 && irq === 1'b1) k_irq = k;
            checks++;
            if (txd !== exp_txd()) begin
                errors++; $display("FAIL b2b_txd cyc=%0d got %b want %b", cyc, txd, exp_txd());
            end
            checks++;
            if (irq !== exp_irq()) begin
                errors++; $display("FAIL b2b_irq cyc=%0d got %b want %b", cyc, irq, exp_irq());
            end
        end
        // The first pop is 1 edge after the first write, and three frames
        // follow back to back. The loop starts 3 edges after the first write.
        checks++;
        if (k_irq != 3 * FL - 2) begin
            errors++; $display("FAIL b2b_irq_rise got %0d want %0d", k_irq, 3 * FL - 2);
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] w;
        logic [63:0] v;
        w    = rand64();
        w[1] = 1'b0;
        bus_write(BASE, w);
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (txd !== exp_txd()) begin
                errors++; $display("FAIL mid_pre_txd cyc=%0d got %b want %b", cyc, txd, exp_txd());
            end
        end
        #1;
        reset = 1'b1;
        m_clear();
        #1;
        checks++;
        if (txd !== 1'b1) begin
            errors++; $display("FAIL mid_reset_txd got %b want 1", txd);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL mid_reset_irq got %b want 1", irq);
        end
        bus_read(STAT, v);
        checks++;
        if (v !== {56'b0, PAR, 7'h02}) begin
            errors++; $display("FAIL mid_reset_status got %h want %h", v, {56'b0, PAR, 7'h02});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2 * FL; i++) begin
            step();
            checks++;
            if (txd !== 1'b1) begin
                errors++; $display("FAIL mid_after_txd cyc=%0d got %b want 1", cyc, txd);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] v;
        int          r;
        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            if (r < 22) begin
                bus_write(BASE, rand64());
            end else if (r < 27) begin
                bus_write(STAT, rand64());
            end else begin
                if (r < 35) begin
                    bus_read(STAT, v);
                    checks++;
                    if (v !== exp_status()) begin
                        errors++; $display("FAIL rand_status cyc=%0d got %h want %h", cyc, v, exp_status());
                    end
                end
                step();
            end
            checks++;
            if (txd !== exp_txd()) begin
                errors++; $display("FAIL rand_txd cyc=%0d got %b want %b", cyc, txd, exp_txd());
            end
            checks++;
            if (irq !== exp_irq()) begin
                errors++; $display("FAIL rand_irq cyc=%0d got %b want %b", cyc, irq, exp_irq());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
